// File: rtl/uart1_rx.sv
// uart1_rx: 8N1 asynchronous serial receiver, receive-side partner of uart1.
//
// Samples the asynchronous rx pin through a two-flop synchronizer, times each
// bit from the detected start edge, samples at mid-bit, and holds the received
// byte for a consumer using a valid/ack handshake.
//
// Parameters:
//   CLKS_PER_BIT  clk_48 cycles per serial bit (8..65535)
//   HALF_BIT      cycles from detected start edge to start-bit mid-sample
//
// Ports:
//   clk_48     in   system clock
//   rst        in   synchronous active-high reset
//   rx         in   asynchronous serial line, idle high
//   rx_ack     in   consumer strobe; clears rx_valid and overrun
//   rx_data    out  last accepted byte, stable while rx_valid is high
//   rx_valid   out  byte available, held until acked
//   rx_busy    out  receiver not idle (registered)
//   frame_err  out  one-cycle pulse when a stop bit samples low
//   overrun    out  sticky: a byte completed while rx_valid was already high

module uart1_rx #(
    parameter int unsigned CLKS_PER_BIT = 2500,
    parameter int unsigned HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk_48,
    input  logic       rst,
    input  logic       rx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] BitReload  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HalfReload = TW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    state_e state_q, state_d;

    logic          rx_meta_q;
    logic          rx_s;
    logic [TW-1:0] timer_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          deliver_q;
    logic          tick;

    logic load_half;
    logic load_bit;
    logic clr_cnt;
    logic shift_en;
    logic deliver;
    logic ferr;

    assign tick = (timer_q == '0);

    // Two-flop synchronizer; idle level is high so reset to 1.
    always_ff @(posedge clk_48) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s      <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s      <= rx_meta_q;
        end
    end

    // State register.
    always_ff @(posedge clk_48) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!rx_s) state_d = StStart;
            StStart: if (tick) state_d = rx_s ? StIdle : StData;
            StData:  if (tick && bit_cnt_q == 3'd7) state_d = StStop;
            StStop:  if (tick) state_d = rx_s ? StIdle : StBreak;
            // A held-low line stays here instead of decoding as repeated 0x00.
            StBreak: if (rx_s) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        load_half = 1'b0;
        load_bit  = 1'b0;
        clr_cnt   = 1'b0;
        shift_en  = 1'b0;
        deliver   = 1'b0;
        ferr      = 1'b0;
        unique case (state_q)
            StIdle: load_half = !rx_s;
            StStart: begin
                if (tick && !rx_s) begin
                    load_bit = 1'b1;
                    clr_cnt  = 1'b1;
                end
            end
            StData: begin
                if (tick) begin
                    shift_en = 1'b1;
                    load_bit = 1'b1;
                end
            end
            StStop: begin
                if (tick) begin
                    deliver = rx_s;
                    ferr    = !rx_s;
                end
            end
            default: ;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_48) begin
        if (rst) begin
            timer_q   <= '0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            deliver_q <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load_half) begin
                timer_q <= HalfReload;
            end else if (load_bit) begin
                timer_q <= BitReload;
            end else if (!tick) begin
                timer_q <= timer_q - TW'(1);
            end

            if (clr_cnt) begin
                bit_cnt_q <= 3'd0;
            end else if (shift_en) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end

            // LSB arrives first, so shift right and enter at the MSB.
            if (shift_en) begin
                shift_q <= {rx_s, shift_q[7:1]};
            end

            deliver_q <= deliver;
            frame_err <= ferr;
            rx_busy   <= (state_q != StIdle);

            // Handshake is resolved the cycle after the stop sample; an ack in
            // that cycle consumes the old byte so the new one may load.
            if (deliver_q) begin
                if (!rx_valid || rx_ack) begin
                    rx_data  <= shift_q;
                    rx_valid <= 1'b1;
                    if (rx_ack) begin
                        overrun <= 1'b0;
                    end
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule
